// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the integer execution unit and its neighbours: opcode
// width, ROB tag width and the named primary-op encodings that the decoder,
// the reservation station and the ALU all agree on.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int CALC_OP_L1_NUM_WIDTH = 4;
    localparam int ROB_SIZE_WIDTH       = 5;

    typedef logic [31:0]               word_t;
    typedef logic [ROB_SIZE_WIDTH-1:0] rob_tag_t;

    // Bit 3 clear: arithmetic selected by funct3. Bit 3 set: branch compare.
    // Encodings 10 and 11 are reserved and intentionally absent.
    typedef enum logic [CALC_OP_L1_NUM_WIDTH-1:0] {
        CALC_ADD_SUB = 4'd0,
        CALC_SLL     = 4'd1,
        CALC_SLT     = 4'd2,
        CALC_SLTU    = 4'd3,
        CALC_XOR     = 4'd4,
        CALC_SRL_SRA = 4'd5,
        CALC_OR      = 4'd6,
        CALC_AND     = 4'd7,
        CALC_BEQ     = 4'd8,
        CALC_BNE     = 4'd9,
        CALC_BLT     = 4'd12,
        CALC_BGE     = 4'd13,
        CALC_BLTU    = 4'd14,
        CALC_BGEU    = 4'd15
    } calc_op_e;

    // Compare and set-less-than ops return a 0/1 word.
    function automatic word_t flag_word(input logic f);
        return {31'b0, f};
    endfunction

endpackage

// File: rtl/alu_if.sv
// -----------------------------------------------------------------------------
// alu_if
// Dispatch bus from the reservation station into the ALU plus the ALU result
// broadcast back to its snoopers.
//   rs2alu_ready        dispatch valid (no backpressure)
//   rs2alu_op_L1/_L2    primary op / SUB-SRA variant bit
//   rs2alu_opr1/_opr2   32-bit operands
//   rs2alu_dependency   destination ROB tag
//   alu_valid           one-cycle broadcast pulse
//   alu_value           32-bit result
//   alu_dependency      ROB tag of the result
// Modports: master = dispatching side, slave = ALU.
// -----------------------------------------------------------------------------
interface alu_if;
    import alu_pkg::*;

    logic                            rs2alu_ready;
    logic [CALC_OP_L1_NUM_WIDTH-1:0] rs2alu_op_L1;
    logic                            rs2alu_op_L2;
    word_t                           rs2alu_opr1;
    word_t                           rs2alu_opr2;
    rob_tag_t                        rs2alu_dependency;

    logic                            alu_valid;
    word_t                           alu_value;
    rob_tag_t                        alu_dependency;

    modport master (
        output rs2alu_ready, rs2alu_op_L1, rs2alu_op_L2,
               rs2alu_opr1, rs2alu_opr2, rs2alu_dependency,
        input  alu_valid, alu_value, alu_dependency
    );

    modport slave (
        input  rs2alu_ready, rs2alu_op_L1, rs2alu_op_L2,
               rs2alu_opr1, rs2alu_opr2, rs2alu_dependency,
        output alu_valid, alu_value, alu_dependency
    );

endinterface

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Single-issue, fully pipelined RV32I integer execution unit. Accepts one op
// per cycle from the reservation station and broadcasts the registered result
// exactly one cycle later.
//   clk_in         sole clock, posedge
//   rst_in         synchronous active-high reset (beats rdy_in and flush)
//   rdy_in         global enable; low freezes every output
//   need_flush_in  misprediction flush; drops the same-cycle dispatch
//   bus            alu_if.slave: rs2alu_* dispatch in, alu_* broadcast out
// -----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
(
    input  logic  clk_in,
    input  logic  rst_in,
    input  logic  rdy_in,
    input  logic  need_flush_in,
    alu_if.slave  bus
);

    calc_op_e           op;
    word_t              opr1;
    word_t              opr2;
    logic signed [31:0] opr1_s;
    logic signed [31:0] opr2_s;
    logic [4:0]         shamt;
    word_t              result;

    logic               valid_q, valid_d;
    word_t              value_q, value_d;
    rob_tag_t           dep_q,   dep_d;

    assign op     = calc_op_e'(bus.rs2alu_op_L1);
    assign opr1   = bus.rs2alu_opr1;
    assign opr2   = bus.rs2alu_opr2;
    assign opr1_s = bus.rs2alu_opr1;
    assign opr2_s = bus.rs2alu_opr2;
    assign shamt  = bus.rs2alu_opr2[4:0];

    // Result mux: the variant bit only matters for ADD/SUB and SRL/SRA.
    always_comb begin
        result = '0;
        case (op)
            CALC_ADD_SUB: result = bus.rs2alu_op_L2 ? (opr1 - opr2) : (opr1 + opr2);
            CALC_SLL:     result = opr1 << shamt;
            CALC_SLT:     result = flag_word(opr1_s < opr2_s);
            CALC_SLTU:    result = flag_word(opr1 < opr2);
            CALC_XOR:     result = opr1 ^ opr2;
            CALC_SRL_SRA: result = bus.rs2alu_op_L2 ? word_t'(opr1_s >>> shamt)
                                                    : (opr1 >> shamt);
            CALC_OR:      result = opr1 | opr2;
            CALC_AND:     result = opr1 & opr2;
            CALC_BEQ:     result = flag_word(opr1 == opr2);
            CALC_BNE:     result = flag_word(opr1 != opr2);
            CALC_BLT:     result = flag_word(opr1_s < opr2_s);
            CALC_BGE:     result = flag_word(opr1_s >= opr2_s);
            CALC_BLTU:    result = flag_word(opr1 < opr2);
            CALC_BGEU:    result = flag_word(opr1 >= opr2);
            default:      result = '0;   // reserved 10/11 still broadcast
        endcase
    end

    // Next state: rdy_in low holds everything; a flush kills the pulse but
    // leaves value/tag untouched; an idle cycle holds value/tag.
    always_comb begin
        valid_d = valid_q;
        value_d = value_q;
        dep_d   = dep_q;
        if (rdy_in) begin
            if (need_flush_in) begin
                valid_d = 1'b0;
            end else begin
                valid_d = bus.rs2alu_ready;
                if (bus.rs2alu_ready) begin
                    value_d = result;
                    dep_d   = bus.rs2alu_dependency;
                end
            end
        end
    end

    // Single register stage: outputs must never be combinational from the
    // dispatch inputs, since the RS compares tags against alu_dependency.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= 1'b0;
            value_q <= '0;
            dep_q   <= '0;
        end else begin
            valid_q <= valid_d;
            value_q <= value_d;
            dep_q   <= dep_d;
        end
    end

    assign bus.alu_valid      = valid_q;
    assign bus.alu_value      = value_q;
    assign bus.alu_dependency = dep_q;

endmodule
